// File: rtl/cmp_pkg.sv
// Shared types and defaults for the comparator feeder (compc_feeder) and its
// timeout counter.
package cmp_pkg;

   typedef enum logic [2:0] {
      LOAD_A    = 3'd0,
      LOAD_B    = 3'd1,
      SETUP     = 3'd2,
      WAIT_DONE = 3'd3,
      WAIT_CLR  = 3'd4
   } cmp_state_e;

   localparam int CMP_RESULT_W      = 4;
   localparam int CMP_INPUTSIZE_DEF = 4;
   localparam int CMP_TIMEOUT_DEF   = 15;

endpackage

// File: rtl/cmpf_timeout.sv
// Clearable up-counter for the feeder's wait states; term flags the last
// permitted cycle so the caller can abort on the following edge.
module cmpf_timeout #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic term
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != W'(TIMEOUT_CYCLES))) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Count 0 is the first cycle in the wait state, so TIMEOUT_CYCLES-1 is the last one.
   assign term = (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/compc_feeder.sv
// Operand feeder for the comparator: collects A then B, runs the enable/done
// handshake and returns the captured result. Optional abort: CMPF_TIMEOUT_EN.
module compc_feeder
   import cmp_pkg::*;
#(
   parameter int INPUTSIZE      = CMP_INPUTSIZE_DEF,
   parameter int TIMEOUT_CYCLES = CMP_TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [INPUTSIZE-1:0]      in_data,
   output logic                      in_ready,
   output logic [2*INPUTSIZE-1:0]    data_out,
   output logic                      enable_out,
   input  logic                      done_in,
   input  logic [CMP_RESULT_W-1:0]   result_in,
   output logic [CMP_RESULT_W-1:0]   result_out,
   output logic                      result_valid,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam logic [2:0] ST_LOAD_A    = LOAD_A;
   localparam logic [2:0] ST_LOAD_B    = LOAD_B;
   localparam logic [2:0] ST_SETUP     = SETUP;
   localparam logic [2:0] ST_WAIT_DONE = WAIT_DONE;
   localparam logic [2:0] ST_WAIT_CLR  = WAIT_CLR;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("compc_feeder: TIMEOUT_CYCLES must be at least 1");
   end

   logic [2:0]           state;
   logic [INPUTSIZE-1:0] a_q;

   assign in_ready = (state == ST_LOAD_A) || (state == ST_LOAD_B);
   assign busy     = (state != ST_LOAD_A);

`ifdef CMPF_TIMEOUT_EN
   logic tmo_inc;
   logic tmo_term;
   logic tmo_err_q;

   // Counting only while staying put means every entry into a wait state restarts at 0.
   assign tmo_inc = ((state == ST_WAIT_DONE) && !done_in) || (state == ST_WAIT_CLR);

   cmpf_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk  (clk),
      .rst  (rst),
      .clr  (!tmo_inc),
      .inc  (tmo_inc),
      .term (tmo_term)
   );

   assign timeout_err = tmo_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_LOAD_A;
         a_q          <= '0;
         data_out     <= '0;
         enable_out   <= 1'b0;
         result_out   <= '0;
         result_valid <= 1'b0;
`ifdef CMPF_TIMEOUT_EN
         tmo_err_q    <= 1'b0;
`endif
      end else begin
         result_valid <= 1'b0;
         case (state)
            ST_LOAD_A: begin
               if (in_valid) begin
                  a_q   <= in_data;
                  state <= ST_LOAD_B;
`ifdef CMPF_TIMEOUT_EN
                  tmo_err_q <= 1'b0;
`endif
               end
            end
            ST_LOAD_B: begin
               if (in_valid) begin
                  data_out <= {a_q, in_data};
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               enable_out <= 1'b1;
               state      <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (done_in) begin
                  result_out <= result_in;
                  enable_out <= 1'b0;
                  state      <= ST_WAIT_CLR;
               end
`ifdef CMPF_TIMEOUT_EN
               else if (tmo_term) begin
                  enable_out <= 1'b0;
                  tmo_err_q  <= 1'b1;
                  state      <= ST_LOAD_A;
               end
`endif
            end
            ST_WAIT_CLR: begin
               if (!done_in) begin
                  result_valid <= 1'b1;
                  state        <= ST_LOAD_A;
               end
`ifdef CMPF_TIMEOUT_EN
               else if (tmo_term) begin
                  tmo_err_q <= 1'b1;
                  state     <= ST_LOAD_A;
               end
`endif
            end
            default: begin
               enable_out <= 1'b0;
               state      <= ST_LOAD_A;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_compc_feeder.sv
// Scoreboard bench for compc_feeder with a behavioural comparator model;
// the abort scenario runs only when CMPF_TIMEOUT_EN is defined.
module tb_compc_feeder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic [7:0] data_out;
   logic       enable_out;
   logic       done_in   = 1'b0;
   logic [3:0] result_in = 4'h0;
   logic [3:0] result_out;
   logic       result_valid;
   logic       busy;
   logic       timeout_err;

   compc_feeder #(
      .INPUTSIZE      (4),
      .TIMEOUT_CYCLES (15)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .data_out     (data_out),
      .enable_out   (enable_out),
      .done_in      (done_in),
      .result_in    (result_in),
      .result_out   (result_out),
      .result_valid (result_valid),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Comparator model: done rises once enable has been high for dly samples,
   // drops after enable has been low for a full cycle; result = (A == B).
   int dly = 1;
   int hi  = 0;
   bit prev_en = 1'b0;
   always @(posedge clk) begin
      #1;
      if (enable_out) begin
         hi++;
         if (hi >= dly) done_in = 1'b1;
      end else begin
         hi = 0;
         if (!prev_en) done_in = 1'b0;
      end
      prev_en   = enable_out;
      result_in = {3'b000, data_out[7:4] == data_out[3:0]};
   end

   typedef struct {
      logic [3:0] res;
      bit         lat;
      int         hs;
   } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      if (result_valid) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result_valid: got 1 expected 0 (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result_out", 32'(result_out), 32'(e.res));
            if (e.lat) chk("rv_latency", 32'(cyc - e.hs), 32'd4);
         end
      end
   end

   task automatic push(input logic [3:0] d, output int hs);
      int g = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("push_ready", 32'(in_ready), 32'd1);
      hs = cyc + 1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pair(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] res, input bit lat);
      int h;
      push(a, h);
      push(b, h);
      sb.push_back('{res: res, lat: lat, hs: h});
   endtask

   task automatic wait_en_high();
      int g = 0;
      @(negedge clk);
      while (!enable_out && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("enable_rise", 32'(enable_out), 32'd1);
   endtask

   task automatic wait_drain();
      int g = 0;
      while (sb.size() != 0 && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("scoreboard_drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},     32'(in_ready), 32'd1);
      chk({tag, "_busy"},         32'(busy), 32'd0);
      chk({tag, "_data_out"},     32'(data_out), 32'h00);
      chk({tag, "_enable_out"},   32'(enable_out), 32'd0);
      chk({tag, "_result_out"},   32'(result_out), 32'h0);
      chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
      chk({tag, "_timeout_err"},  32'(timeout_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      int n;
      int h;
      int rvc;

      rst = 1'b1;
      in_valid = 1'b0;
      in_data  = 4'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("por");
      rst = 1'b0;

      // Basic compare and minimum round trip
      dly = 1;
      pair(4'h9, 4'h9, 4'h1, 1'b1);
      chk("basic_data_out", 32'(data_out), 32'h99);
      chk("basic_setup_enable", 32'(enable_out), 32'd0);
      chk("basic_busy", 32'(busy), 32'd1);
      wait_drain();

      // Strobes held during SETUP/WAIT_DONE/WAIT_CLR are ignored
      pair(4'h2, 4'h6, 4'h0, 1'b1);
      in_valid = 1'b1;
      in_data  = 4'h3;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         chk("ignored_data_out", 32'(data_out), 32'h26);
         n++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("ignored_busy_cycles", 32'(n), 32'd4);
      pair(4'hC, 4'hD, 4'h0, 1'b1);
      chk("after_ignored_data_out", 32'(data_out), 32'hCD);
      wait_drain();

      // Back-to-back: A2 offered in the result_valid cycle
      pair(4'h5, 4'hA, 4'h0, 1'b1);
      n = 0;
      @(negedge clk);
      while (!result_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_rv_seen", 32'(result_valid), 32'd1);
      chk("b2b_in_ready_with_rv", 32'(in_ready), 32'd1);
      rvc = cyc;
      push(4'h7, h);
      chk("b2b_a_accept_edge", 32'(h), 32'(rvc + 1));
      push(4'h7, h);
      sb.push_back('{res: 4'h1, lat: 1'b1, hs: h});
      wait_drain();
      chk("b2b_result_out", 32'(result_out), 32'h1);

      // Synchronous reset while waiting for done
      dly = 1000;
      push(4'h1, h);
      push(4'h1, h);
      wait_en_high();
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_edge_enable", 32'(enable_out), 32'd0);
      chk("rst_edge_in_ready", 32'(in_ready), 32'd1);
      chk("rst_edge_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("midrst");
      rst = 1'b0;
      dly = 1;
      repeat (3) @(negedge clk);

      // Slow done: enable held, result captured only on done
      dly = 10;
      pair(4'h3, 4'h3, 4'h1, 1'b0);
      wait_en_high();
      n = 0;
      while (enable_out && n < 100) begin
         chk("slow_result_held", 32'(result_out), 32'h0);
         n++;
         @(negedge clk);
      end
      chk("slow_enable_cycles", 32'(n), 32'd10);
      wait_drain();
      dly = 1;

`ifdef CMPF_TIMEOUT_EN
      // done stuck low: abort after 15 WAIT_DONE cycles
      dly = 1000;
      push(4'hE, h);
      push(4'hF, h);
      wait_en_high();
      n = 0;
      while (enable_out && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_enable_cycles", 32'(n), 32'd15);
      chk("tmo_err_set", 32'(timeout_err), 32'd1);
      chk("tmo_in_ready", 32'(in_ready), 32'd1);
      chk("tmo_result_held", 32'(result_out), 32'h1);
      repeat (3) @(negedge clk);
      chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
      dly = 1;
      push(4'h2, h);
      chk("tmo_err_cleared_by_a", 32'(timeout_err), 32'd0);
      push(4'h2, h);
      sb.push_back('{res: 4'h1, lat: 1'b1, hs: h});
      wait_drain();
`else
      chk("no_macro_timeout_err", 32'(timeout_err), 32'd0);
`endif

      repeat (5) @(negedge clk);
      chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
